z80_bus_tracer: RTL and testbench
=================================

# z80_bus_tracer

Passive bus observer that sits directly downstream of the `chip_z80` pins in the z80 test SoC. It samples the CPU control strobes, address and data buses on each rising edge of the CPU phase clock and classifies each new bus transaction: fetch, memory read/write, I/O read/write, reset edge, halt. Each classified transaction becomes one timestamped record, buffered in a small FIFO and drained over a valid/ready stream. It replaces ad-hoc `$display` logging with a synthesizable, checkable record stream.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `eclk`  in  1  system clock; the only clock.
- `ereset`  in  1  reset, synchronous, active-high.
- `clk`  in  1  CPU phase clock, synchronous to `eclk`; sampled as a signal, never used as a clock.
- `_m1, _mreq, _iorq, _rd, _wr, _reset, _halt`  in  1 each  CPU strobes, active-low.
- `ab`  in  16  address bus.
- `db_i`  in  8  data into CPU (read data).
- `db_o`  in  8  data out of CPU (write data).
- `rec_valid`  out  1  record available.
- `rec_ready`  in  1  consumer accepts the record when high together with `rec_valid`.
- `rec_kind`  out  3  0 fetch, 1 mem rd, 2 mem wr, 3 io rd, 4 io wr, 5 reset asserted, 6 reset released, 7 halted.
- `rec_addr`  out  16  captured `ab`; 0 for kinds 5–7.
- `rec_data`  out  8  `db_i` for reads/fetch, `db_o` for writes, 0 otherwise.
- `rec_stamp`  out  16  phase-clock count at capture.
- `ovf_cnt`  out  8  records lost to a full FIFO; saturates at 255.
- `halted`  out  1  sticky, set when a halt record is generated.

## Operation
- `clk_q` registers `clk` each `eclk`; `tick = clk & ~clk_q`. All evaluation happens only in tick cycles.
- Edge history registers `rd_l, wr_l, rst_l, halt_l` load `_rd, _wr, _reset, _halt` on every tick.
- Candidate events on a tick:
  - halt: `halt_l & ~_halt & ~halted`.
  - reset asserted: `rst_l & ~_reset`.
  - reset released: `~rst_l & _reset`.
  - rd: `rd_l & ~_rd`, with kind:
    - fetch if `~_mreq & ~_m1`;
    - mem rd if `~_mreq & _m1`;
    - io rd if `_mreq & ~_iorq`;
    - no record if neither `_mreq` nor `_iorq` is low.
  - wr: `wr_l & ~_wr`, with kind mem wr if `~_mreq`, else io wr if `~_iorq`.
- At most one record per tick. Priority: halt > reset asserted/released > rd > wr. Lower-priority candidates on the same tick are discarded and not counted.
- Stamp counter: 16-bit, increments on every tick, wraps 0xFFFF→0. A record carries the pre-increment value.
- Push when full: the record is dropped and `ovf_cnt` increments, saturating.
- Push and pop in the same cycle when full: both succeed, no overflow.
- Pop when empty is impossible because `rec_valid` = 0.
- After the halt record, further halt events are suppressed; other events still log.

## Timing
- Reset values:
  - outputs: `rec_valid`=0, `rec_kind/addr/data/stamp`=0, `ovf_cnt`=0, `halted`=0;
  - internal: FIFO empty, stamp=0, `clk_q`=0;
  - `rd_l/wr_l/rst_l/halt_l`=1, so no spurious edge on the first tick.
- Latency: event sampled in tick cycle N → pushed at end of N → `rec_valid`=1 in N+1 if the FIFO was empty.
- `rec_*` outputs are registered and stable while `rec_valid & ~rec_ready`.
- Throughput: one pop per `eclk`.
- `ereset` mid-operation: FIFO contents, stamp, counters and `halted` are cleared in the same cycle, and in-flight records are lost.

## Structure
- Package `z80_trace_pkg`: `trace_kind_t` enum (3-bit values above) and `trace_rec_t` struct (kind, addr, data, stamp; 43 bits).
- Sub-module `trace_fifo`: parameterized synchronous FIFO of `trace_rec_t` with full/empty and registered output; the tracer contains only tick detection, classification, stamp and overflow logic.

## Test plan
- Opcode fetch: `_m1=_mreq=0`, `_rd` falls, `ab`=0x0000, `db_i`=0x3E, stamp 5 → one record {0, 0x0000, 0x3E, 5}, `rec_valid` one `eclk` after the tick.
- Writes: mem wr `ab`=0xFFFE, `db_o`=0xF5 → kind 2; I/O wr with `_iorq=0`, `ab`=0x0010, `db_o`=0xAA → kind 4 with data 0xAA.
- Reset sequence: hold `_reset`=0 for 3 ticks, then release → exactly kinds 5 then 6; no records while low without strobe edges.
- Overflow: `rec_ready`=0, generate 20 reads with `DEPTH`=16 → 16 records retained in order, `ovf_cnt`=4. Then pop while pushing on a full FIFO → no further overflow.
- Simultaneous events: `_halt` and `_rd` fall on the same tick → only kind 7, `halted`=1. A second `_halt` edge later → no record.
- Stamp wrap and reset: run 65537 ticks then a fetch → stamp 1. Assert `ereset` with 3 queued records → `rec_valid`=0 next cycle, `ovf_cnt`=0.

Source files
------------

// File: rtl/z80_trace_pkg.sv
// Shared record kinds and the packed trace record carried through the tracer FIFO.
package z80_trace_pkg;

  typedef enum logic [2:0] {
    K_FETCH   = 3'd0,
    K_MEM_RD  = 3'd1,
    K_MEM_WR  = 3'd2,
    K_IO_RD   = 3'd3,
    K_IO_WR   = 3'd4,
    K_RST_ON  = 3'd5,
    K_RST_OFF = 3'd6,
    K_HALT    = 3'd7
  } trace_kind_t;

  typedef struct packed {
    trace_kind_t kind;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [15:0] stamp;
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace records; the head entry is held in an output register
// so it stays stable until popped.
module trace_fifo
  import z80_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  trace_rec_t i_din,
  input  logic       i_pop,
  output logic       o_full,
  output logic       o_valid,
  output trace_rec_t o_dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  trace_rec_t    r_mem [DEPTH];
  trace_rec_t    r_dout;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_n;
  logic [CW-1:0] r_cnt, w_cnt_pop, w_cnt_n;
  logic          w_pop, w_push;

  assign o_valid    = (r_cnt != '0);
  assign o_full     = (r_cnt == CW'(DEPTH));
  assign o_dout     = r_dout;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop      = i_pop & o_valid;
  assign w_push     = i_push & (~o_full | w_pop);
  assign w_cnt_pop  = r_cnt - CW'(w_pop);
  assign w_cnt_n    = w_cnt_pop + CW'(w_push);
  assign w_rd_ptr_n = r_rd_ptr + AW'(w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      r_cnt    <= w_cnt_n;
      r_rd_ptr <= w_rd_ptr_n;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Next head is the incoming record when nothing older remains after the pop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dout <= '0;
    end else if (w_cnt_n != '0) begin
      r_dout <= (w_cnt_pop == '0) ? i_din : r_mem[w_rd_ptr_n];
    end
  end

endmodule

// File: rtl/z80_bus_tracer.sv
// Passive Z80 bus observer: detects phase-clock ticks, classifies strobe edges into
// timestamped records and queues them for a valid/ready consumer.
module z80_bus_tracer
  import z80_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        eclk,
  input  logic        ereset,
  input  logic        clk,
  input  logic        _m1,
  input  logic        _mreq,
  input  logic        _iorq,
  input  logic        _rd,
  input  logic        _wr,
  input  logic        _reset,
  input  logic        _halt,
  input  logic [15:0] ab,
  input  logic [7:0]  db_i,
  input  logic [7:0]  db_o,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [2:0]  rec_kind,
  output logic [15:0] rec_addr,
  output logic [7:0]  rec_data,
  output logic [15:0] rec_stamp,
  output logic [7:0]  ovf_cnt,
  output logic        halted
);

  logic        r_clk_q, r_rd_l, r_wr_l, r_rst_l, r_halt_l, r_halted;
  logic [15:0] r_stamp;
  logic [7:0]  r_ovf;
  logic        w_tick, w_push, w_set_halt, w_full, w_pop, w_drop;
  trace_rec_t  w_rec, w_dout;

  assign w_tick = clk & ~r_clk_q;
  assign w_pop  = rec_valid & rec_ready;
  assign w_drop = w_push & w_full & ~w_pop;

  // Priority order: halt, reset edges, read, write; losers on a tick are discarded.
  always_comb begin
    w_push       = 1'b0;
    w_set_halt   = 1'b0;
    w_rec        = '0;
    w_rec.stamp  = r_stamp;
    if (w_tick) begin
      if (r_halt_l & ~_halt & ~r_halted) begin
        w_push     = 1'b1;
        w_set_halt = 1'b1;
        w_rec.kind = K_HALT;
      end else if (r_rst_l & ~_reset) begin
        w_push     = 1'b1;
        w_rec.kind = K_RST_ON;
      end else if (~r_rst_l & _reset) begin
        w_push     = 1'b1;
        w_rec.kind = K_RST_OFF;
      end else if (r_rd_l & ~_rd & ~(_mreq & _iorq)) begin
        w_push     = 1'b1;
        w_rec.addr = ab;
        w_rec.data = db_i;
        w_rec.kind = ~_mreq ? (~_m1 ? K_FETCH : K_MEM_RD) : K_IO_RD;
      end else if (r_wr_l & ~_wr & ~(_mreq & _iorq)) begin
        w_push     = 1'b1;
        w_rec.addr = ab;
        w_rec.data = db_o;
        w_rec.kind = ~_mreq ? K_MEM_WR : K_IO_WR;
      end
    end
  end

  always_ff @(posedge eclk) begin
    if (ereset) begin
      r_clk_q  <= 1'b0;
      r_rd_l   <= 1'b1;
      r_wr_l   <= 1'b1;
      r_rst_l  <= 1'b1;
      r_halt_l <= 1'b1;
      r_stamp  <= '0;
      r_ovf    <= '0;
      r_halted <= 1'b0;
    end else begin
      r_clk_q <= clk;
      if (w_tick) begin
        r_rd_l   <= _rd;
        r_wr_l   <= _wr;
        r_rst_l  <= _reset;
        r_halt_l <= _halt;
        r_stamp  <= r_stamp + 16'd1;
      end
      if (w_set_halt) r_halted <= 1'b1;
      if (w_drop && (r_ovf != 8'hFF)) r_ovf <= r_ovf + 8'd1;
    end
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (eclk),
    .i_rst   (ereset),
    .i_push  (w_push),
    .i_din   (w_rec),
    .i_pop   (rec_ready),
    .o_full  (w_full),
    .o_valid (rec_valid),
    .o_dout  (w_dout)
  );

  assign rec_kind  = w_dout.kind;
  assign rec_addr  = w_dout.addr;
  assign rec_data  = w_dout.data;
  assign rec_stamp = w_dout.stamp;
  assign ovf_cnt   = r_ovf;
  assign halted    = r_halted;

endmodule

// File: tb/tb_z80_bus_tracer.sv
// Bench for z80_bus_tracer: directed vector table, hand sequences for the multi-cycle
// cases and random strobes checked against a queue-based record model.
module tb_z80_bus_tracer;

  localparam int DEPTH = 16;

  logic        eclk = 1'b0, ereset = 1'b1, cpu_clk = 1'b0;
  logic        s_m1 = 1'b1, s_mreq = 1'b1, s_iorq = 1'b1, s_rd = 1'b1, s_wr = 1'b1;
  logic        s_reset = 1'b1, s_halt = 1'b1;
  logic [15:0] s_ab = '0;
  logic [7:0]  s_dbi = '0, s_dbo = '0;
  logic        rec_ready = 1'b1;
  logic        rec_valid, halted;
  logic [2:0]  rec_kind;
  logic [15:0] rec_addr, rec_stamp;
  logic [7:0]  rec_data, ovf_cnt;

  always #5 eclk = ~eclk;

  z80_bus_tracer #(.DEPTH(DEPTH)) dut (
    .eclk(eclk), .ereset(ereset), .clk(cpu_clk),
    ._m1(s_m1), ._mreq(s_mreq), ._iorq(s_iorq), ._rd(s_rd), ._wr(s_wr),
    ._reset(s_reset), ._halt(s_halt),
    .ab(s_ab), .db_i(s_dbi), .db_o(s_dbo),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_kind(rec_kind), .rec_addr(rec_addr), .rec_data(rec_data), .rec_stamp(rec_stamp),
    .ovf_cnt(ovf_cnt), .halted(halted)
  );

  typedef struct {
    int kind;
    int addr;
    int data;
    int stamp;
  } exp_t;

  typedef struct {
    logic m1, mreq, iorq, rd, wr;
    logic [15:0] ab;
    logic [7:0] dbi, dbo;
    logic has;
    int kind, addr, data;
  } vec_t;

  int n_err = 0, n_chk = 0;

  // Reference model state
  exp_t     m_q[$];
  bit [15:0] m_stamp;
  int       m_ovf;
  bit       m_halted, m_clk_q;
  bit       m_prev_rd, m_prev_wr, m_prev_rst, m_prev_halt;

  // Samples taken at the most recent negedge, and records the consumer accepted
  logic        smp_valid, smp_halted;
  logic [2:0]  smp_kind;
  logic [15:0] smp_addr, smp_stamp;
  logic [7:0]  smp_data, smp_ovf;
  int          popped_kind[$];
  int          popped_addr[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_stamp = '0; m_ovf = 0; m_halted = 1'b0; m_clk_q = 1'b0;
    m_prev_rd = 1'b1; m_prev_wr = 1'b1; m_prev_rst = 1'b1; m_prev_halt = 1'b1;
  endtask

  task automatic model_tick();
    exp_t r;
    bit   emit;
    bit   mem_cyc, io_cyc;
    emit    = 1'b0;
    mem_cyc = !s_mreq;
    io_cyc  = s_mreq && !s_iorq;
    r.kind  = 0; r.addr = 0; r.data = 0; r.stamp = int'(m_stamp);
    if (m_prev_halt && !s_halt && !m_halted) begin
      emit = 1'b1; r.kind = 7; m_halted = 1'b1;
    end else if (m_prev_rst != s_reset) begin
      emit = 1'b1; r.kind = s_reset ? 6 : 5;
    end else if (m_prev_rd && !s_rd && (mem_cyc || io_cyc)) begin
      emit = 1'b1; r.addr = int'(s_ab); r.data = int'(s_dbi);
      r.kind = io_cyc ? 3 : (s_m1 ? 1 : 0);
    end else if (m_prev_wr && !s_wr && (mem_cyc || io_cyc)) begin
      emit = 1'b1; r.addr = int'(s_ab); r.data = int'(s_dbo);
      r.kind = io_cyc ? 4 : 2;
    end
    if (emit) begin
      if (m_q.size() < DEPTH) m_q.push_back(r);
      else if (m_ovf < 255) m_ovf++;
    end
    m_prev_rd = s_rd; m_prev_wr = s_wr; m_prev_rst = s_reset; m_prev_halt = s_halt;
    m_stamp = m_stamp + 16'd1;
  endtask

  // One eclk cycle with the CPU phase clock at cv; outputs checked against the model.
  task automatic step(input logic cv);
    cpu_clk = cv;
    @(negedge eclk);
    smp_valid = rec_valid; smp_kind = rec_kind; smp_addr = rec_addr; smp_data = rec_data;
    smp_stamp = rec_stamp; smp_ovf = ovf_cnt; smp_halted = halted;
    chk("rec_valid", rec_valid, m_q.size() != 0);
    chk("ovf_cnt", ovf_cnt, m_ovf);
    chk("halted", halted, m_halted);
    if (m_q.size() != 0) begin
      chk("rec_kind", rec_kind, m_q[0].kind);
      chk("rec_addr", rec_addr, m_q[0].addr);
      chk("rec_data", rec_data, m_q[0].data);
      chk("rec_stamp", rec_stamp, m_q[0].stamp);
    end
    if (rec_valid && rec_ready) begin
      popped_kind.push_back(int'(rec_kind));
      popped_addr.push_back(int'(rec_addr));
      if (m_q.size() != 0) void'(m_q.pop_front());
    end
    if (cv && !m_clk_q) model_tick();
    m_clk_q = cv;
    @(posedge eclk); #1;
  endtask

  task automatic tick();
    step(1'b0);
    step(1'b1);
  endtask

  task automatic idle_bus();
    s_m1 = 1'b1; s_mreq = 1'b1; s_iorq = 1'b1; s_rd = 1'b1; s_wr = 1'b1;
    s_reset = 1'b1; s_halt = 1'b1;
  endtask

  task automatic do_reset();
    ereset = 1'b1; cpu_clk = 1'b0;
    idle_bus();
    @(negedge eclk); @(posedge eclk); #1;
    ereset = 1'b0;
    model_clear();
  endtask

  task automatic mem_read(input logic [15:0] a, input logic [7:0] d);
    idle_bus(); tick();
    s_mreq = 1'b0; s_rd = 1'b0; s_ab = a; s_dbi = d;
    tick();
  endtask

  vec_t vt[8];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 8'h3E, 8'h00, 1'b1, 0, 'h1234, 'h3E};
    vt[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h8000, 8'h5A, 8'h00, 1'b1, 1, 'h8000, 'h5A};
    vt[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00FE, 8'h77, 8'h00, 1'b1, 3, 'h00FE, 'h77};
    vt[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFE, 8'h11, 8'hF5, 1'b1, 2, 'hFFFE, 'hF5};
    vt[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 8'h22, 8'hAA, 1'b1, 4, 'h0010, 'hAA};
    vt[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h4444, 8'h33, 8'h00, 1'b0, 0, 0, 0};
    vt[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h5555, 8'h00, 8'h66, 1'b0, 0, 0, 0};
    vt[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0042, 8'h99, 8'h00, 1'b1, 0, 'h0042, 'h99};

    // Reset state
    model_clear();
    do_reset();
    step(1'b0);
    chk("reset rec_valid", smp_valid, 0);
    chk("reset rec_kind", smp_kind, 0);
    chk("reset rec_addr", smp_addr, 0);
    chk("reset rec_data", smp_data, 0);
    chk("reset rec_stamp", smp_stamp, 0);
    chk("reset ovf_cnt", smp_ovf, 0);
    chk("reset halted", smp_halted, 0);

    // Opcode fetch at stamp 5, rec_valid one eclk after the tick
    for (int i = 0; i < 5; i++) tick();
    s_m1 = 1'b0; s_mreq = 1'b0; s_rd = 1'b0; s_ab = 16'h0000; s_dbi = 8'h3E;
    step(1'b0);
    step(1'b1);
    chk("fetch valid in tick cycle", smp_valid, 0);
    step(1'b0);
    chk("fetch valid", smp_valid, 1);
    chk("fetch kind", smp_kind, 0);
    chk("fetch addr", smp_addr, 0);
    chk("fetch data", smp_data, 'h3E);
    chk("fetch stamp", smp_stamp, 5);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      idle_bus(); tick(); step(1'b0);
      s_m1 = vt[i].m1; s_mreq = vt[i].mreq; s_iorq = vt[i].iorq;
      s_rd = vt[i].rd; s_wr = vt[i].wr; s_ab = vt[i].ab; s_dbi = vt[i].dbi; s_dbo = vt[i].dbo;
      tick();
      step(1'b0);
      chk($sformatf("vec%0d valid", i), smp_valid, vt[i].has);
      if (vt[i].has) begin
        chk($sformatf("vec%0d kind", i), smp_kind, vt[i].kind);
        chk($sformatf("vec%0d addr", i), smp_addr, vt[i].addr);
        chk($sformatf("vec%0d data", i), smp_data, vt[i].data);
      end
    end

    // Reset pin held low for 3 ticks then released
    idle_bus(); tick(); step(1'b0);
    popped_kind.delete();
    s_reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    s_reset = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) step(1'b0);
    chk("rst seq count", popped_kind.size(), 2);
    if (popped_kind.size() == 2) begin
      chk("rst seq first", popped_kind[0], 5);
      chk("rst seq second", popped_kind[1], 6);
    end

    // Overflow: 20 reads into a stalled FIFO, then pop+push while full
    rec_ready = 1'b0;
    popped_addr.delete();
    for (int i = 0; i < 20; i++) mem_read(16'(i), 8'(i + 8'h40));
    step(1'b0);
    chk("ovf after 20", smp_ovf, 4);
    idle_bus(); tick();
    s_mreq = 1'b0; s_rd = 1'b0; s_ab = 16'h0100; s_dbi = 8'hC3;
    step(1'b0);
    rec_ready = 1'b1;
    step(1'b1);
    rec_ready = 1'b0;
    step(1'b0);
    chk("ovf after pop+push", smp_ovf, 4);
    rec_ready = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0);
    chk("ovf retained count", popped_addr.size(), 17);
    if (popped_addr.size() == 17) begin
      chk("ovf first addr", popped_addr[0], 0);
      chk("ovf last kept addr", popped_addr[15], 15);
      chk("ovf late addr", popped_addr[16], 'h100);
    end

    // ereset with records queued and a nonzero overflow count
    rec_ready = 1'b0;
    for (int i = 0; i < 20; i++) mem_read(16'(i + 16'h200), 8'(i));
    do_reset();
    step(1'b0);
    chk("ereset valid", smp_valid, 0);
    chk("ereset ovf", smp_ovf, 0);
    rec_ready = 1'b1;

    // Halt and read on the same tick, then a second halt edge
    idle_bus(); tick();
    s_halt = 1'b0; s_mreq = 1'b0; s_rd = 1'b0; s_ab = 16'h7777;
    tick();
    step(1'b0);
    chk("halt valid", smp_valid, 1);
    chk("halt kind", smp_kind, 7);
    chk("halt addr", smp_addr, 0);
    chk("halted set", smp_halted, 1);
    idle_bus(); tick(); tick();
    s_halt = 1'b0;
    tick();
    step(1'b0);
    chk("second halt valid", smp_valid, 0);
    chk("halted sticky", smp_halted, 1);

    // Random strobes and back-pressure
    do_reset();
    for (int i = 0; i < 800; i++) begin
      s_m1    = 1'($urandom_range(0, 1));
      s_mreq  = 1'($urandom_range(0, 1));
      s_iorq  = 1'($urandom_range(0, 1));
      s_rd    = 1'($urandom_range(0, 1));
      s_wr    = 1'($urandom_range(0, 1));
      s_reset = ($urandom_range(0, 15) != 0);
      s_halt  = ($urandom_range(0, 40) != 0);
      s_ab    = 16'($urandom);
      s_dbi   = 8'($urandom);
      s_dbo   = 8'($urandom);
      rec_ready = ($urandom_range(0, 3) != 0);
      step(1'b0);
      rec_ready = ($urandom_range(0, 3) != 0);
      step(1'b1);
    end
    rec_ready = 1'b1;
    idle_bus();
    for (int i = 0; i < 40; i++) step(1'b0);

    // Stamp wrap: 65537 ticks then a fetch carries stamp 1
    do_reset();
    for (int i = 0; i < 65537; i++) tick();
    s_m1 = 1'b0; s_mreq = 1'b0; s_rd = 1'b0; s_ab = 16'h0000; s_dbi = 8'h3E;
    tick();
    step(1'b0);
    chk("wrap valid", smp_valid, 1);
    chk("wrap kind", smp_kind, 0);
    chk("wrap stamp", smp_stamp, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
